// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART byte FIFO.
package uart_pkg;

    // Receive error tag stored alongside each byte: break, framing, parity.
    typedef struct packed {
        logic bi;
        logic fe;
        logic pe;
    } uart_err_t;

    localparam int UART_FIFO_DEPTH_DEF = 16;

endpackage

// File: rtl/uart_fifo_gen_if.sv
// Handshake and status bundle between a UART FIFO and its users.
// The FIFO takes the slave modport. The register interface or shift engine,
// or the bench, takes the master modport.
interface uart_fifo_gen_if
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = UART_FIFO_DEPTH_DEF
) ();
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             en;
    logic             flush;
    logic             push_in;
    logic             pop_in;
    logic [WIDTH-1:0] din;
    uart_err_t        err_in;
    logic [LVL_W-1:0] thres;
    logic             ovr_clr;

    logic [WIDTH-1:0] dout;
    uart_err_t        err_out;
    logic             err_any;
    logic [LVL_W-1:0] level;
    logic             empty;
    logic             full;
    logic             overrun;
    logic             underrun;
    logic             thres_tri;

    modport master (
        output en, flush, push_in, pop_in, din, err_in, thres, ovr_clr,
        input  dout, err_out, err_any, level, empty, full, overrun, underrun, thres_tri
    );

    modport slave (
        input  en, flush, push_in, pop_in, din, err_in, thres, ovr_clr,
        output dout, err_out, err_any, level, empty, full, overrun, underrun, thres_tri
    );
endinterface

// File: rtl/uart_fifo_gen.sv
// Generic show-ahead UART FIFO with occupancy level, flush, sticky overrun,
// underrun pulse and a programmable trigger level.
// Optional feature macro: UART_FIFO_ERRTAG_EN stores a 3-bit error tag per
// entry and tracks how many stored entries carry a nonzero tag.
module uart_fifo_gen
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = UART_FIFO_DEPTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    uart_fifo_gen_if.slave bus
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic             overrun_q;
    logic             underrun_q;

    logic is_empty;
    logic is_full;
    logic push_req;
    logic pop_req;
    logic flush_req;
    logic wr_ok;
    logic rd_ok;
    logic ovr_set;

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == LVL_W'(DEPTH));

    // Decode the requests; flush beats push/pop, and a pop on a full FIFO frees the slot for a push.
    always_comb begin
        flush_req = bus.en & bus.flush;
        push_req  = bus.en & bus.push_in & ~bus.flush;
        pop_req   = bus.en & bus.pop_in & ~bus.flush;
        rd_ok     = pop_req & ~is_empty;
        wr_ok     = push_req & (~is_full | rd_ok);
        ovr_set   = push_req & is_full & ~rd_ok;
    end

    // Pointers and occupancy level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush_req) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_ok && !rd_ok)      level_q <= level_q + LVL_W'(1);
            else if (rd_ok && !wr_ok) level_q <= level_q - LVL_W'(1);
        end
    end

    // Data storage; contents survive reset, only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= bus.din;
    end

    // Sticky overrun (set wins over clear) and single-cycle underrun pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (ovr_set)                  overrun_q <= 1'b1;
            else if (bus.en && bus.ovr_clr) overrun_q <= 1'b0;
            underrun_q <= pop_req & is_empty;
        end
    end

    // Status outputs and show-ahead head entry.
    always_comb begin
        bus.level     = level_q;
        bus.empty     = is_empty;
        bus.full      = is_full;
        bus.overrun   = overrun_q;
        bus.underrun  = underrun_q;
        bus.thres_tri = (bus.thres != '0) && (level_q >= bus.thres);
        bus.dout      = is_empty ? '0 : mem[rd_ptr];
    end

`ifdef UART_FIFO_ERRTAG_EN
    uart_err_t        err_mem [DEPTH];
    logic [LVL_W-1:0] err_cnt;
    logic             tag_in;
    logic             tag_head;

    assign tag_in   = (bus.err_in != '0);
    assign tag_head = (err_mem[rd_ptr] != '0);

    // Tag storage written in lockstep with the data array.
    always_ff @(posedge clk) begin
        if (wr_ok) err_mem[wr_ptr] <= bus.err_in;
    end

    // Count of stored entries carrying a nonzero tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (flush_req) begin
            err_cnt <= '0;
        end else begin
            if ((wr_ok && tag_in) && !(rd_ok && tag_head))
                err_cnt <= err_cnt + LVL_W'(1);
            else if ((rd_ok && tag_head) && !(wr_ok && tag_in))
                err_cnt <= err_cnt - LVL_W'(1);
        end
    end

    // Head tag follows dout; summary flag from the counter.
    always_comb begin
        bus.err_out = is_empty ? '0 : err_mem[rd_ptr];
        bus.err_any = (err_cnt != '0);
    end
`else
    logic unused_err_in;
    assign unused_err_in = ^bus.err_in;

    // Tagging not built: tag outputs tied off.
    always_comb begin
        bus.err_out = '0;
        bus.err_any = 1'b0;
    end
`endif

endmodule

// File: tb/tb_uart_fifo_gen.sv
// Directed bench for uart_fifo_gen, DEPTH=16, WIDTH=8.
module tb_uart_fifo_gen;
    import uart_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    uart_fifo_gen_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    uart_fifo_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given requests; outputs sampled 1 time unit after the edge.
    task automatic cyc(input logic push, input logic pop, input logic [7:0] d);
        bus.push_in = push;
        bus.pop_in  = pop;
        bus.din     = d;
        @(posedge clk);
        #1;
        bus.push_in = 1'b0;
        bus.pop_in  = 1'b0;
        bus.flush   = 1'b0;
        bus.ovr_clr = 1'b0;
        bus.err_in  = '0;
    endtask

    initial begin
        bus.en      = 1'b1;
        bus.flush   = 1'b0;
        bus.push_in = 1'b0;
        bus.pop_in  = 1'b0;
        bus.din     = '0;
        bus.err_in  = '0;
        bus.thres   = 5'd10;
        bus.ovr_clr = 1'b0;

        // Reset state
        #12;
        check("rst_level",    32'(bus.level), 32'd0);
        check("rst_empty",    32'(bus.empty), 32'd1);
        check("rst_full",     32'(bus.full), 32'd0);
        check("rst_overrun",  32'(bus.overrun), 32'd0);
        check("rst_underrun", 32'(bus.underrun), 32'd0);
        check("rst_thres",    32'(bus.thres_tri), 32'd0);
        check("rst_dout",     32'(bus.dout), 32'd0);
        check("rst_err_any",  32'(bus.err_any), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            check("fill_level", 32'(bus.level), 32'(i));
            check("fill_dout",  32'(bus.dout), 32'h01);
            check("fill_thres", 32'(bus.thres_tri), (i >= 10) ? 32'd1 : 32'd0);
        end
        check("full_flag", 32'(bus.full), 32'd1);
        check("full_nemp", 32'(bus.empty), 32'd0);

        // Push on full is dropped and raises sticky overrun
        cyc(1'b1, 1'b0, 8'hAA);
        check("ovr_level", 32'(bus.level), 32'd16);
        check("ovr_set",   32'(bus.overrun), 32'd1);
        check("ovr_dout",  32'(bus.dout), 32'h01);
        cyc(1'b0, 1'b0, 8'h00);
        check("ovr_sticky", 32'(bus.overrun), 32'd1);
        bus.ovr_clr = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        check("ovr_clr", 32'(bus.overrun), 32'd0);

        // Drain in order
        for (int i = 1; i <= 16; i++) begin
            check("drain_dout", 32'(bus.dout), 32'(i));
            cyc(1'b0, 1'b1, 8'h00);
            check("drain_level", 32'(bus.level), 32'(16 - i));
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
        check("drain_dout0", 32'(bus.dout), 32'd0);
        check("drain_nover", 32'(bus.overrun), 32'd0);

        // Pop on empty: one-cycle underrun
        cyc(1'b0, 1'b1, 8'h00);
        check("udr_pulse", 32'(bus.underrun), 32'd1);
        check("udr_level", 32'(bus.level), 32'd0);
        cyc(1'b0, 1'b0, 8'h00);
        check("udr_clear", 32'(bus.underrun), 32'd0);

        // Push+pop on empty: push taken, pop flagged
        cyc(1'b1, 1'b1, 8'h33);
        check("pp_emp_level", 32'(bus.level), 32'd1);
        check("pp_emp_udr",   32'(bus.underrun), 32'd1);
        check("pp_emp_dout",  32'(bus.dout), 32'h33);
        cyc(1'b0, 1'b1, 8'h00);
        check("pp_emp_pop",   32'(bus.level), 32'd0);
        check("pp_emp_udr0",  32'(bus.underrun), 32'd0);

        // Refill (pointers now at 1, so this wraps) then push+pop while full
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(i));
        check("refill_full", 32'(bus.full), 32'd1);
        cyc(1'b1, 1'b1, 8'h55);
        check("ppf_level", 32'(bus.level), 32'd16);
        check("ppf_novr",  32'(bus.overrun), 32'd0);
        check("ppf_dout",  32'(bus.dout), 32'h02);
        for (int i = 2; i <= 16; i++) begin
            check("wrap_dout", 32'(bus.dout), 32'(i));
            cyc(1'b0, 1'b1, 8'h00);
        end
        check("wrap_last",  32'(bus.dout), 32'h55);
        check("wrap_level", 32'(bus.level), 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        check("wrap_empty", 32'(bus.empty), 32'd1);

        // Flush at level 7 with a simultaneous push
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
        check("pre_flush_level", 32'(bus.level), 32'd7);
        bus.flush = 1'b1;
        cyc(1'b1, 1'b0, 8'h77);
        check("flush_level", 32'(bus.level), 32'd0);
        check("flush_empty", 32'(bus.empty), 32'd1);

        // en=0 holds state
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
        bus.en = 1'b0;
        cyc(1'b1, 1'b1, 8'hEE);
        check("dis_level", 32'(bus.level), 32'd3);
        check("dis_dout",  32'(bus.dout), 32'hC0);
        bus.flush = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        check("dis_flush", 32'(bus.level), 32'd3);
        cyc(1'b0, 1'b1, 8'h00);
        check("dis_udr", 32'(bus.underrun), 32'd0);
        bus.en = 1'b1;

        // Trigger-level boundaries at level 3
        bus.thres = 5'd3;
        #1;
        check("thr_eq", 32'(bus.thres_tri), 32'd1);
        bus.thres = 5'd4;
        #1;
        check("thr_above", 32'(bus.thres_tri), 32'd0);
        bus.thres = 5'd0;
        #1;
        check("thr_zero", 32'(bus.thres_tri), 32'd0);
        bus.thres = 5'd17;
        #1;
        check("thr_big", 32'(bus.thres_tri), 32'd0);
        bus.thres = 5'd10;

        // Error tags
        bus.flush = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        bus.err_in = 3'b010;
        cyc(1'b1, 1'b0, 8'h41);
        bus.err_in = 3'b000;
        cyc(1'b1, 1'b0, 8'h42);
`ifdef UART_FIFO_ERRTAG_EN
        check("tag_any",  32'(bus.err_any), 32'd1);
        check("tag_head", 32'(bus.err_out), 32'b010);
`else
        check("tag_any_off",  32'(bus.err_any), 32'd0);
        check("tag_head_off", 32'(bus.err_out), 32'd0);
`endif
        cyc(1'b0, 1'b1, 8'h00);
        check("tag_pop_dout", 32'(bus.dout), 32'h42);
        check("tag_pop_any",  32'(bus.err_any), 32'd0);
        check("tag_pop_head", 32'(bus.err_out), 32'd0);

        // Async reset mid-operation
        #2;
        rst = 1'b1;
        #1;
        check("arst_level", 32'(bus.level), 32'd0);
        check("arst_dout",  32'(bus.dout), 32'd0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
